flag_unit: RTL and testbench

Flag register and condition evaluator downstream of the 8-bit ALU/accumulator stage. It latches the ALU's zero, parity, carry and aux-carry outputs plus the result sign into an 8085-layout PSW flag byte, under per-instruction update rules. It also loads and drives the flag byte over the shared flag data bus for PUSH PSW / POP PSW. It produces a registered branch-condition bit for Jcc/Ccc/Rcc.

---
 rtl/flag_unit_if.sv | 32 +++
 rtl/flag_unit.sv | 117 +++++++++++
 tb/tb_flag_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/flag_unit_if.sv
// ALU-side handshake into the PSW flag unit: flag update controls, condition
// select and the registered flag/condition outputs.
interface flag_unit_if;
   logic [7:0] alu_res;
   logic       zero_in;
   logic       parity_in;
   logic       carry_in;
   logic       aux_in;
   logic       op_a7;
   logic       op_b7;
   logic       sub;
   logic       flag_we;
   logic [2:0] flag_op;
   logic       psw_load;
   logic       psw_drive;
   logic [2:0] ccc;
   logic       cond_eval;
   logic       cond_out;
   logic [7:0] flags;

   modport master (
      output alu_res, zero_in, parity_in, carry_in, aux_in, op_a7, op_b7, sub,
             flag_we, flag_op, psw_load, psw_drive, ccc, cond_eval,
      input  cond_out, flags
   );

   modport slave (
      input  alu_res, zero_in, parity_in, carry_in, aux_in, op_a7, op_b7, sub,
             flag_we, flag_op, psw_load, psw_drive, ccc, cond_eval,
      output cond_out, flags
   );
endinterface

// File: rtl/flag_unit.sv
// 8085 PSW flag register and Jcc/Ccc/Rcc condition evaluator, clocked on the
// falling edge. Define FLAG_UNDOC_EN to add the undocumented V (bit 1) and K (bit 5).
module flag_unit (
   input  logic        clk,
   input  logic        rst,
   flag_unit_if.slave  bus,
   inout  wire  [7:0]  flagdbus
);
   localparam int S_B  = 7;
   localparam int Z_B  = 6;
   localparam int AC_B = 4;
   localparam int P_B  = 2;
   localparam int CY_B = 0;

   localparam logic [2:0] OP_HOLD   = 3'd0;
   localparam logic [2:0] OP_ARITH  = 3'd1;
   localparam logic [2:0] OP_INCDEC = 3'd2;
   localparam logic [2:0] OP_AND    = 3'd3;
   localparam logic [2:0] OP_ORXOR  = 3'd4;
   localparam logic [2:0] OP_ROT    = 3'd5;
   localparam logic [2:0] OP_STC    = 3'd6;
   localparam logic [2:0] OP_CMC    = 3'd7;

`ifdef FLAG_UNDOC_EN
   localparam int          K_B      = 5;
   localparam int          V_B      = 1;
   localparam logic [7:0]  PSW_MASK = 8'hF7;
`else
   localparam logic [7:0]  PSW_MASK = 8'hD5;
`endif

   logic [7:0] flags_q;
   logic [7:0] nxt;
   logic       cond_q;

   logic s_n, z_n, p_n, cy_n;
   assign s_n  = bus.alu_res[7];
   assign z_n  = bus.zero_in;
   assign p_n  = ~bus.parity_in;
   assign cy_n = bus.carry_in ^ bus.sub;

`ifdef FLAG_UNDOC_EN
   logic b_eff, v_n, k_n;
   assign b_eff = bus.op_b7 ^ bus.sub;
   assign v_n   = (bus.op_a7 == b_eff) & (bus.alu_res[7] != bus.op_a7);
   assign k_n   = (bus.op_a7 & b_eff) | (bus.op_a7 & bus.alu_res[7]) |
                  (b_eff & bus.alu_res[7]);
`else
   logic unused_undoc;
   assign unused_undoc = ^{bus.op_a7, bus.op_b7};
`endif

   function automatic logic cond_of(input logic [2:0] c, input logic [7:0] f);
      case (c)
         3'd0:    return ~f[Z_B];
         3'd1:    return  f[Z_B];
         3'd2:    return ~f[CY_B];
         3'd3:    return  f[CY_B];
         3'd4:    return ~f[P_B];
         3'd5:    return  f[P_B];
         3'd6:    return ~f[S_B];
         default: return  f[S_B];
      endcase
   endfunction

   // psw_load wins over flag_we; the result also feeds the cond_eval bypass
   always_comb begin
      nxt = flags_q;
      if (bus.psw_load) begin
         nxt = flagdbus & PSW_MASK;
      end else if (bus.flag_we) begin
         case (bus.flag_op)
            OP_HOLD: ;
            OP_ARITH: begin
               nxt[S_B] = s_n; nxt[Z_B] = z_n; nxt[AC_B] = bus.aux_in;
               nxt[P_B] = p_n; nxt[CY_B] = cy_n;
`ifdef FLAG_UNDOC_EN
               nxt[V_B] = v_n; nxt[K_B] = k_n;
`endif
            end
            OP_INCDEC: begin
               nxt[S_B] = s_n; nxt[Z_B] = z_n; nxt[AC_B] = bus.aux_in;
               nxt[P_B] = p_n;
`ifdef FLAG_UNDOC_EN
               nxt[V_B] = v_n; nxt[K_B] = k_n;
`endif
            end
            OP_AND: begin
               nxt[S_B] = s_n; nxt[Z_B] = z_n; nxt[P_B] = p_n;
               nxt[AC_B] = 1'b1; nxt[CY_B] = 1'b0;
            end
            OP_ORXOR: begin
               nxt[S_B] = s_n; nxt[Z_B] = z_n; nxt[P_B] = p_n;
               nxt[AC_B] = 1'b0; nxt[CY_B] = 1'b0;
            end
            OP_ROT: nxt[CY_B] = bus.carry_in;
            OP_STC: nxt[CY_B] = 1'b1;
            OP_CMC: nxt[CY_B] = ~flags_q[CY_B];
            default: ;
         endcase
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         flags_q <= 8'h00;
         cond_q  <= 1'b0;
      end else begin
         flags_q <= nxt;
         if (bus.cond_eval) cond_q <= cond_of(bus.ccc, nxt);
      end
   end

   assign bus.flags    = flags_q;
   assign bus.cond_out = cond_q;
   assign flagdbus     = bus.psw_drive ? flags_q : 8'bz;
endmodule

// File: tb/tb_flag_unit.sv
// Directed-vector bench for flag_unit; expected values hand-computed for both
// the default build and FLAG_UNDOC_EN.
module tb_flag_unit;
`ifdef FLAG_UNDOC_EN
   localparam bit UNDOC = 1'b1;
`else
   localparam bit UNDOC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tb_bus;
   logic       tb_bus_en;
   wire  [7:0] flagdbus;
   int         checks = 0;
   int         errors = 0;

   flag_unit_if fif();

   assign flagdbus = tb_bus_en ? tb_bus : 8'bz;

   flag_unit dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (fif.slave),
      .flagdbus (flagdbus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %02h expected %02h", tag, got, exp);
      end
   endtask

   // one falling edge, then sample clear of it
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic alu(input logic [7:0] res, input logic z, input logic par,
                      input logic cy, input logic ac, input logic sb);
      fif.alu_res = res; fif.zero_in = z; fif.parity_in = par;
      fif.carry_in = cy; fif.aux_in = ac; fif.sub = sb;
   endtask

   task automatic op(input logic [2:0] o);
      fif.flag_we = 1'b1; fif.flag_op = o;
      tick();
      fif.flag_we = 1'b0;
   endtask

   logic [2:0] cc_sel [6];
   logic       cc_exp [6];

   initial begin
      rst = 1'b1; tb_bus = 8'h00; tb_bus_en = 1'b0;
      fif.op_a7 = 1'b0; fif.op_b7 = 1'b0;
      fif.psw_load = 1'b0; fif.psw_drive = 1'b0;
      fif.ccc = 3'd0; fif.cond_eval = 1'b0;
      alu(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      fif.flag_we = 1'b1; fif.flag_op = 3'd1;

      // reset dominates a pending ARITH
      tick();
      chk("reset_flags", fif.flags, 8'h00);
      chk("reset_cond", {7'd0, fif.cond_out}, 8'h00);
      tb_bus_en = 1'b1; tb_bus = 8'hA5; #1;
      chk("reset_bus_released", flagdbus, 8'hA5);
      tb_bus_en = 1'b0;
      rst = 1'b0; fif.flag_we = 1'b0;

      op(3'd1);
      chk("arith_55", fif.flags, 8'h55);

      alu(8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      fif.op_a7 = 1'b0; fif.op_b7 = 1'b1;
      op(3'd1);
      chk("arith_sub_noborrow", fif.flags, UNDOC ? 8'h82 : 8'h80);
      op(3'd7);
      chk("cmc", fif.flags, UNDOC ? 8'h83 : 8'h81);

      fif.op_b7 = 1'b0;
      op(3'd6);
      chk("stc", fif.flags, UNDOC ? 8'h83 : 8'h81);
      alu(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      op(3'd2);
      chk("incdec_cy_held", fif.flags, 8'h01);

      alu(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      op(3'd3);
      chk("and", fif.flags, 8'h54);
      alu(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      op(3'd4);
      chk("orxor", fif.flags, 8'h84);
      alu(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      op(3'd5);
      chk("rot_ignores_sub", fif.flags, 8'h85);
      op(3'd0);
      chk("hold_op", fif.flags, 8'h85);
      fif.flag_op = 3'd1; tick();
      chk("no_we", fif.flags, 8'h85);

      // psw_load beats a coinciding flag_we
      tb_bus_en = 1'b1; tb_bus = 8'hFF;
      fif.psw_load = 1'b1; fif.flag_we = 1'b1; fif.flag_op = 3'd7;
      tick();
      fif.psw_load = 1'b0; fif.flag_we = 1'b0; tb_bus_en = 1'b0;
      chk("psw_load_ff", fif.flags, UNDOC ? 8'hF7 : 8'hD5);
      fif.psw_drive = 1'b1; #1;
      chk("psw_drive", flagdbus, UNDOC ? 8'hF7 : 8'hD5);
      fif.psw_drive = 1'b0;

      tb_bus_en = 1'b1; tb_bus = 8'h2A; fif.psw_load = 1'b1;
      tick();
      fif.psw_load = 1'b0; tb_bus_en = 1'b0;
      chk("psw_load_2a", fif.flags, UNDOC ? 8'h22 : 8'h00);

      // same-edge bypass: old Z=0, new Z=1
      alu(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      fif.ccc = 3'd1; fif.cond_eval = 1'b1;
      op(3'd1);
      chk("arith_bypass_flags", fif.flags, 8'h44);
      chk("cond_bypass_z", {7'd0, fif.cond_out}, 8'h01);
      fif.ccc = 3'd0; tick();
      chk("cond_nz", {7'd0, fif.cond_out}, 8'h00);
      fif.cond_eval = 1'b0; fif.ccc = 3'd1; tick();
      chk("cond_hold", {7'd0, fif.cond_out}, 8'h00);

      // flags = 44: S0 Z1 P1 CY0
      cc_sel = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      cc_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      fif.cond_eval = 1'b1;
      for (int i = 0; i < 6; i++) begin
         fif.ccc = cc_sel[i]; tick();
         chk($sformatf("cond_ccc%0d", cc_sel[i]), {7'd0, fif.cond_out}, {7'd0, cc_exp[i]});
      end

      // mid-sequence reset discards pending writes
      fif.ccc = 3'd5; fif.flag_we = 1'b1; fif.flag_op = 3'd6; rst = 1'b1;
      tick();
      rst = 1'b0; fif.flag_we = 1'b0; fif.cond_eval = 1'b0;
      chk("midrst_flags", fif.flags, 8'h00);
      chk("midrst_cond", {7'd0, fif.cond_out}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
